mem_request_initiator: RTL and testbench

//  Client-side initiator for the memory controller request/return interface. Accepts

---
 rtl/mem_request_initiator.sv | 177 +++++++++++++++++
 tb/tb_mem_request_initiator.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_request_initiator.sv
// Client-side request initiator: issues wr/rd strobes, tracks outstanding tags in a
// small table, matches returns, and flags timeouts and unmatched returns.
module mem_request_initiator #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_write,
  input  logic [ADDR_W-1:0]                cmd_address,
  input  logic [DATA_W-1:0]                cmd_data,
  output logic [ADDR_W-1:0]                wr_address,
  output logic                             wr_en,
  output logic [DATA_W-1:0]                wr_data,
  input  logic [ADDR_W-1:0]                wr_ret_address,
  input  logic                             wr_ret_ack,
  output logic [ADDR_W-1:0]                rd_address,
  output logic                             rd_en,
  input  logic [DATA_W-1:0]                rd_ret_data,
  input  logic [ADDR_W-1:0]                rd_ret_address,
  input  logic                             rd_ret_ack,
  output logic                             wr_resp_valid,
  output logic [ADDR_W-1:0]                wr_resp_address,
  output logic                             rd_resp_valid,
  output logic [ADDR_W-1:0]                rd_resp_address,
  output logic [DATA_W-1:0]                rd_resp_data,
  input  logic                             flush_req,
  output logic                             flush_done,
  output logic [$clog2(MAX_OUTST+1)-1:0]   outst_count,
  output logic                             err_unmatched,
  output logic                             err_timeout
);
  localparam int unsigned CNT_W = $clog2(MAX_OUTST+1);
  localparam int unsigned AGE_W = $clog2(TIMEOUT+1);
  localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(TIMEOUT-1);

  typedef enum logic {SLOT_FREE = 1'b0, SLOT_PENDING = 1'b1} slot_e;

  slot_e                state_q [MAX_OUTST];
  slot_e                state_d [MAX_OUTST];
  logic [AGE_W-1:0]     age_q   [MAX_OUTST];
  logic [AGE_W-1:0]     age_d   [MAX_OUTST];
  logic [ADDR_W-1:0]    tag_q   [MAX_OUTST];
  logic [MAX_OUTST-1:0] kind_q;  // 1 = write entry
  logic [MAX_OUTST-1:0] alloc_sel, wr_hit, rd_hit, to_hit, freed;
  logic                 any_free, dup, found, accept;
  logic [CNT_W-1:0]     count_q, count_d;

  logic                 wr_en_q, rd_en_q, wr_resp_valid_q, rd_resp_valid_q;
  logic [ADDR_W-1:0]    req_addr_q, wr_resp_addr_q, rd_resp_addr_q;
  logic [DATA_W-1:0]    wr_data_q, rd_resp_data_q;
  logic                 err_unmatched_q, err_timeout_q;

  // Acceptance looks only at registered slot state, so a slot freed this edge is not reused.
  always_comb begin
    any_free  = 1'b0;
    dup       = 1'b0;
    found     = 1'b0;
    alloc_sel = '0;
    for (int unsigned i = 0; i < MAX_OUTST; i++) begin
      if (state_q[i] == SLOT_FREE) begin
        any_free = 1'b1;
        if (!found) begin
          alloc_sel[i] = 1'b1;
          found        = 1'b1;
        end
      end else if (kind_q[i] == cmd_write && tag_q[i] == cmd_address) begin
        dup = 1'b1;
      end
    end
  end

  assign cmd_ready = !flush_req && any_free && !dup;
  assign accept    = cmd_valid && cmd_ready;

  // A return that matches wins over a timeout landing on the same edge.
  always_comb begin
    wr_hit = '0;
    rd_hit = '0;
    to_hit = '0;
    for (int unsigned i = 0; i < MAX_OUTST; i++) begin
      wr_hit[i] = (state_q[i] == SLOT_PENDING) && kind_q[i] && wr_ret_ack &&
                  (tag_q[i] == wr_ret_address);
      rd_hit[i] = (state_q[i] == SLOT_PENDING) && !kind_q[i] && rd_ret_ack &&
                  (tag_q[i] == rd_ret_address);
      to_hit[i] = (state_q[i] == SLOT_PENDING) && !wr_hit[i] && !rd_hit[i] &&
                  (age_q[i] == AGE_LAST);
    end
    freed = wr_hit | rd_hit | to_hit;
  end

  always_comb begin
    count_d = count_q;
    if (accept) count_d = count_d + CNT_W'(1);
    for (int unsigned i = 0; i < MAX_OUTST; i++) begin
      state_d[i] = state_q[i];
      age_d[i]   = age_q[i];
      if (freed[i]) begin
        state_d[i] = SLOT_FREE;
        count_d    = count_d - CNT_W'(1);
      end else if (state_q[i] == SLOT_PENDING && age_q[i] != '1) begin
        age_d[i] = age_q[i] + AGE_W'(1);
      end
      if (accept && alloc_sel[i]) begin
        state_d[i] = SLOT_PENDING;
        age_d[i]   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MAX_OUTST; i++) begin
        state_q[i] <= SLOT_FREE;
        age_q[i]   <= '0;
        tag_q[i]   <= '0;
      end
      kind_q          <= '0;
      count_q         <= '0;
      wr_en_q         <= 1'b0;
      rd_en_q         <= 1'b0;
      req_addr_q      <= '0;
      wr_data_q       <= '0;
      wr_resp_valid_q <= 1'b0;
      wr_resp_addr_q  <= '0;
      rd_resp_valid_q <= 1'b0;
      rd_resp_addr_q  <= '0;
      rd_resp_data_q  <= '0;
      err_unmatched_q <= 1'b0;
      err_timeout_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      age_q   <= age_d;
      count_q <= count_d;
      for (int unsigned i = 0; i < MAX_OUTST; i++) begin
        if (accept && alloc_sel[i]) begin
          kind_q[i] <= cmd_write;
          tag_q[i]  <= cmd_address;
        end
      end
      wr_en_q <= accept && cmd_write;
      rd_en_q <= accept && !cmd_write;
      if (accept) req_addr_q <= cmd_address;
      if (accept && cmd_write) wr_data_q <= cmd_data;
      wr_resp_valid_q <= |wr_hit;
      if (|wr_hit) wr_resp_addr_q <= wr_ret_address;
      rd_resp_valid_q <= |rd_hit;
      if (|rd_hit) begin
        rd_resp_addr_q <= rd_ret_address;
        rd_resp_data_q <= rd_ret_data;
      end
      err_unmatched_q <= err_unmatched_q || (wr_ret_ack && !(|wr_hit)) ||
                         (rd_ret_ack && !(|rd_hit));
      err_timeout_q   <= err_timeout_q || (|to_hit);
    end
  end

  assign wr_en           = wr_en_q;
  assign rd_en           = rd_en_q;
  assign wr_address      = req_addr_q;
  assign rd_address      = req_addr_q;
  assign wr_data         = wr_data_q;
  assign wr_resp_valid   = wr_resp_valid_q;
  assign wr_resp_address = wr_resp_addr_q;
  assign rd_resp_valid   = rd_resp_valid_q;
  assign rd_resp_address = rd_resp_addr_q;
  assign rd_resp_data    = rd_resp_data_q;
  assign outst_count     = count_q;
  assign flush_done      = flush_req && (count_q == '0);
  assign err_unmatched   = err_unmatched_q;
  assign err_timeout     = err_timeout_q;

endmodule

// File: tb/tb_mem_request_initiator.sv
// Directed bench for mem_request_initiator: expected strobes and responses are queued
// when stimulus is driven and compared when the DUT presents them.
module tb_mem_request_initiator;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned MO = 4;
  localparam int unsigned TO = 16;
  localparam int unsigned CW = $clog2(MO+1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_address = '0;
  logic [DW-1:0] cmd_data = '0;
  logic [AW-1:0] wr_address, rd_address, wr_resp_address, rd_resp_address;
  logic          wr_en, rd_en, wr_resp_valid, rd_resp_valid;
  logic [DW-1:0] wr_data, rd_resp_data;
  logic [AW-1:0] wr_ret_address = '0, rd_ret_address = '0;
  logic          wr_ret_ack = 1'b0, rd_ret_ack = 1'b0;
  logic [DW-1:0] rd_ret_data = '0;
  logic          flush_req = 1'b0, flush_done, err_unmatched, err_timeout;
  logic [CW-1:0] outst_count;

  mem_request_initiator #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MO), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_data(cmd_data),
    .wr_address(wr_address), .wr_en(wr_en), .wr_data(wr_data),
    .wr_ret_address(wr_ret_address), .wr_ret_ack(wr_ret_ack),
    .rd_address(rd_address), .rd_en(rd_en), .rd_ret_data(rd_ret_data),
    .rd_ret_address(rd_ret_address), .rd_ret_ack(rd_ret_ack),
    .wr_resp_valid(wr_resp_valid), .wr_resp_address(wr_resp_address),
    .rd_resp_valid(rd_resp_valid), .rd_resp_address(rd_resp_address),
    .rd_resp_data(rd_resp_data), .flush_req(flush_req), .flush_done(flush_done),
    .outst_count(outst_count), .err_unmatched(err_unmatched), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } item_t;

  item_t req_sb[$];
  item_t wr_rsp_sb[$];
  item_t rd_rsp_sb[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_strobe();
    item_t e;
    e = req_sb.pop_front();
    chk("wr_en", 32'(wr_en), 32'(e.wr));
    chk("rd_en", 32'(rd_en), 32'(!e.wr));
    if (e.wr) begin
      chk("wr_address", 32'(wr_address), 32'(e.addr));
      chk("wr_data", 32'(wr_data), 32'(e.data));
    end else begin
      chk("rd_address", 32'(rd_address), 32'(e.addr));
    end
  endtask

  // Drive one command from a negedge; the strobe is checked one cycle later.
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    item_t it;
    cmd_valid = 1'b1; cmd_write = w; cmd_address = a; cmd_data = d;
    #1 chk("cmd_ready_accept", 32'(cmd_ready), 32'd1);
    it.wr = w; it.addr = a; it.data = d;
    req_sb.push_back(it);
    tick();
    cmd_valid = 1'b0;
    check_strobe();
  endtask

  task automatic ret(input logic wa, input logic [AW-1:0] waddr,
                     input logic ra, input logic [AW-1:0] raddr, input logic [DW-1:0] rdata,
                     input logic exp_wr, input logic exp_rd);
    item_t it, e;
    wr_ret_ack = wa; wr_ret_address = waddr;
    rd_ret_ack = ra; rd_ret_address = raddr; rd_ret_data = rdata;
    if (exp_wr) begin it.wr = 1'b1; it.addr = waddr; it.data = '0; wr_rsp_sb.push_back(it); end
    if (exp_rd) begin it.wr = 1'b0; it.addr = raddr; it.data = rdata; rd_rsp_sb.push_back(it); end
    tick();
    wr_ret_ack = 1'b0; rd_ret_ack = 1'b0;
    chk("wr_resp_valid", 32'(wr_resp_valid), 32'(exp_wr));
    chk("rd_resp_valid", 32'(rd_resp_valid), 32'(exp_rd));
    if (wr_resp_valid && wr_rsp_sb.size() > 0) begin
      e = wr_rsp_sb.pop_front();
      chk("wr_resp_address", 32'(wr_resp_address), 32'(e.addr));
    end
    if (rd_resp_valid && rd_rsp_sb.size() > 0) begin
      e = rd_rsp_sb.pop_front();
      chk("rd_resp_address", 32'(rd_resp_address), 32'(e.addr));
      chk("rd_resp_data", 32'(rd_resp_data), 32'(e.data));
    end
    wr_rsp_sb.delete();
    rd_rsp_sb.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    tick();
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_rd_en", 32'(rd_en), 0);
    chk("rst_wr_resp", 32'(wr_resp_valid), 0);
    chk("rst_rd_resp", 32'(rd_resp_valid), 0);
    chk("rst_outst", 32'(outst_count), 0);
    chk("rst_err_unm", 32'(err_unmatched), 0);
    chk("rst_err_to", 32'(err_timeout), 0);
    chk("rst_flush_done", 32'(flush_done), 0);
    rst_n = 1'b1;
    tick();

    // Async reset with three reads in flight
    issue(1'b0, 16'h0100, '0);
    issue(1'b0, 16'h0101, '0);
    issue(1'b0, 16'h0102, '0);
    chk("pre_rst_outst", 32'(outst_count), 3);
    #2 rst_n = 1'b0;
    #1 chk("midrst_rd_en", 32'(rd_en), 0);
    chk("midrst_outst", 32'(outst_count), 0);
    chk("midrst_rd_addr", 32'(rd_address), 0);
    tick();
    rst_n = 1'b1;
    tick();
    issue(1'b0, 16'h0010, '0);
    chk("post_rst_outst", 32'(outst_count), 1);
    ret(1'b0, '0, 1'b1, 16'h0010, 16'h1111, 1'b0, 1'b1);
    chk("post_rst_drain", 32'(outst_count), 0);

    // Single write, strobe for one cycle only
    issue(1'b1, 16'h1234, 16'hBEEF);
    tick();
    chk("wr_en_one_cycle", 32'(wr_en), 0);
    ret(1'b1, 16'h1234, 1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    chk("wr_resp_one_cycle", 32'(wr_resp_valid), 0);
    chk("after_wr_outst", 32'(outst_count), 0);

    // Fill the table with four reads
    issue(1'b0, 16'h0001, '0);
    issue(1'b0, 16'h0002, '0);
    issue(1'b0, 16'h0003, '0);
    issue(1'b0, 16'h0004, '0);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 16'h0005; cmd_data = 16'h5555;
    #1 chk("full_ready", 32'(cmd_ready), 0);
    chk("full_outst", 32'(outst_count), 4);
    cmd_valid = 1'b0;
    ret(1'b0, '0, 1'b1, 16'h0003, 16'h00AA, 1'b0, 1'b1);
    issue(1'b1, 16'h0005, 16'h5555);
    chk("refill_outst", 32'(outst_count), 4);

    // Simultaneous read and write returns
    ret(1'b1, 16'h0005, 1'b1, 16'h0002, 16'h2222, 1'b1, 1'b1);
    chk("dual_free_outst", 32'(outst_count), 2);
    cmd_write = 1'b0; cmd_address = 16'h0001;
    #1 chk("dup_read_ready", 32'(cmd_ready), 0);
    cmd_write = 1'b1;
    #1 chk("diff_kind_ready", 32'(cmd_ready), 1);
    ret(1'b0, '0, 1'b1, 16'h0001, 16'h0101, 1'b0, 1'b1);
    ret(1'b0, '0, 1'b1, 16'h0004, 16'h0404, 1'b0, 1'b1);
    chk("drained_outst", 32'(outst_count), 0);
    chk("no_timeout_yet", 32'(err_timeout), 0);

    // Unmatched return
    chk("pre_unm", 32'(err_unmatched), 0);
    ret(1'b0, '0, 1'b1, 16'h7777, 16'h0777, 1'b0, 1'b0);
    chk("unm_set", 32'(err_unmatched), 1);
    tick();
    tick();
    chk("unm_sticky", 32'(err_unmatched), 1);

    // Timeout while flushing
    issue(1'b0, 16'h0040, '0);
    flush_req = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 16'h0050;
    #1 chk("flush_ready", 32'(cmd_ready), 0);
    chk("flush_busy", 32'(flush_done), 0);
    repeat (15) tick();
    chk("pre_to_outst", 32'(outst_count), 1);
    chk("pre_to_err", 32'(err_timeout), 0);
    chk("pre_to_flush", 32'(flush_done), 0);
    tick();
    chk("to_outst", 32'(outst_count), 0);
    chk("to_err", 32'(err_timeout), 1);
    chk("flush_done", 32'(flush_done), 1);
    chk("flush_no_rd_en", 32'(rd_en), 0);
    cmd_valid = 1'b0;
    ret(1'b0, '0, 1'b1, 16'h0040, 16'h4040, 1'b0, 1'b0);
    flush_req = 1'b0;
    #1 chk("unflush_ready", 32'(cmd_ready), 1);
    chk("unflush_done", 32'(flush_done), 0);
    chk("to_sticky", 32'(err_timeout), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
